// File: rtl/net_rx_if.sv
// net_rx_if: received frame byte stream from net_rx to downstream logic
//   rx_data   frame byte (destination MAC first, FCS removed)
//   rx_valid  rx_data valid this cycle, no backpressure
//   rx_sop    first byte of frame
//   rx_eop    last non-FCS byte of frame
//   rx_crc_ok verdict, meaningful only with rx_eop
interface net_rx_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_sop;
  logic rx_eop;
  logic rx_crc_ok;
  modport master(output rx_data, rx_valid, rx_sop, rx_eop, rx_crc_ok);
  modport slave(input rx_data, rx_valid, rx_sop, rx_eop, rx_crc_ok);
endinterface

// File: rtl/net_rx.sv
// net_rx: RGMII receiver, strips preamble/SFD and FCS, filters on destination MAC, checks CRC-32
//   clk125    125 MHz receive clock, RGMII sampled on both edges
//   rst_n     asynchronous active-low reset
//   rxctl     RX_DV at rising edge, RX_DV^RX_ER at falling edge
//   rxd       low nibble at falling edge, high nibble at following rising edge
//   rx        frame byte stream (net_rx_if master)
//   frame_cnt frames ending with a good verdict, wraps
//   err_cnt   accepted-address frames ending with a bad verdict, wraps
module net_rx #(
  parameter logic [47:0] MAC_ADDR = 48'h08bf_b8da_8800,
  parameter bit PROMISC = 1'b0,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input logic clk125,
  input logic rst_n,
  input logic rxctl,
  input logic [3:0] rxd,
  net_rx_if.master rx,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DROP = 2'd3;
  localparam logic [5:0][7:0] MAC_B = MAC_ADDR;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hedb8_8320 : 32'h0);
    return r;
  endfunction
  logic [3:0] lo;
  logic ctl_f;
  logic [7:0] rx_byte;
  logic dv, er;
  logic [1:0] state;
  logic [31:0] crc;
  logic [10:0] len;
  logic err_q, mac_ok, bc_ok, runt_err;
  logic [4:0][7:0] hb;
  logic [7:0] mac_b;
  logic addr_chk, mac_hit, bc_hit, addr_fail, verdict;
  always_ff @(negedge clk125 or negedge rst_n)
    if (!rst_n) begin
      lo <= '0;
      ctl_f <= 1'b0;
    end else begin
      lo <= rxd;
      ctl_f <= rxctl;
    end
  assign rx_byte = {rxd, lo};
  assign dv = rxctl;
  assign er = rxctl ^ ctl_f;
  assign mac_b = len > 11'd5 ? 8'h00 : MAC_B[3'd5 - len[2:0]];
  assign addr_chk = state == DATA && dv && len < 11'd6;
  assign mac_hit = mac_ok && rx_byte == mac_b;
  assign bc_hit = bc_ok && rx_byte == 8'hff;
  // a mismatch on any of the first six bytes drops the frame before byte 0 is released
  assign addr_fail = addr_chk && !(mac_hit || bc_hit || PROMISC);
  assign verdict = crc == 32'hdebb_20e3 && !err_q && 32'(len) >= MIN_LEN && 32'(len) <= MAX_LEN;
  always_ff @(posedge clk125 or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      crc <= '1;
      len <= '0;
      err_q <= 1'b0;
      mac_ok <= 1'b0;
      bc_ok <= 1'b0;
      runt_err <= 1'b0;
      hb <= '0;
      rx.rx_data <= '0;
      rx.rx_valid <= 1'b0;
      rx.rx_sop <= 1'b0;
      rx.rx_eop <= 1'b0;
      rx.rx_crc_ok <= 1'b0;
    end else begin
      rx.rx_valid <= 1'b0;
      rx.rx_sop <= 1'b0;
      rx.rx_eop <= 1'b0;
      rx.rx_crc_ok <= 1'b0;
      runt_err <= 1'b0;
      case (state)
        IDLE: state <= !dv ? IDLE : rx_byte == 8'h55 ? PRE : DROP;
        PRE: begin
          state <= !dv ? IDLE : rx_byte == 8'h55 ? PRE : rx_byte == 8'hd5 ? DATA : DROP;
          crc <= '1;
          len <= '0;
          err_q <= 1'b0;
          mac_ok <= 1'b1;
          bc_ok <= 1'b1;
        end
        DATA:
          if (!dv) begin
            state <= IDLE;
            // the oldest held byte is the last non-FCS byte; the four younger ones are the FCS
            if (len >= 11'd5) begin
              rx.rx_valid <= 1'b1;
              rx.rx_data <= hb[4];
              rx.rx_sop <= len == 11'd5;
              rx.rx_eop <= 1'b1;
              rx.rx_crc_ok <= verdict;
            end else runt_err <= PROMISC;
          end else if (addr_fail) state <= DROP;
          else begin
            crc <= crc_byte(crc, rx_byte);
            len <= len == 11'h7ff ? len : len + 11'd1;
            err_q <= err_q | er;
            hb <= {hb[3:0], rx_byte};
            if (addr_chk) begin
              mac_ok <= mac_hit;
              bc_ok <= bc_hit;
            end
            if (len >= 11'd5) begin
              rx.rx_valid <= 1'b1;
              rx.rx_data <= hb[4];
              rx.rx_sop <= len == 11'd5;
            end
          end
        default: state <= dv ? DROP : IDLE;
      endcase
    end
  // counters follow the registered verdict so they move at the end of the eop cycle
  always_ff @(posedge clk125 or negedge rst_n)
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 16'(rx.rx_eop & rx.rx_crc_ok);
      err_cnt <= err_cnt + 16'((rx.rx_eop & !rx.rx_crc_ok) | runt_err);
    end
endmodule

// File: tb/tb_net_rx.sv
// tb_net_rx: directed frames into net_rx (PROMISC=0 and PROMISC=1 instances) with hand-computed expectations
module tb_net_rx;
  logic clk125 = 1'b0;
  logic rst_n = 1'b0;
  logic rxctl = 1'b0;
  logic [3:0] rxd = 4'h0;
  logic [15:0] frame_cnt0, err_cnt0, frame_cnt1, err_cnt1;
  net_rx_if rx0();
  net_rx_if rx1();
  net_rx dut (.clk125(clk125), .rst_n(rst_n), .rxctl(rxctl), .rxd(rxd), .rx(rx0), .frame_cnt(frame_cnt0), .err_cnt(err_cnt0));
  net_rx #(.PROMISC(1'b1)) dut_p (.clk125(clk125), .rst_n(rst_n), .rxctl(rxctl), .rxd(rxd), .rx(rx1), .frame_cnt(frame_cnt1), .err_cnt(err_cnt1));
  always #4 clk125 = ~clk125;
  int nb[2] = '{0, 0};
  int ns[2] = '{0, 0};
  int ne[2] = '{0, 0};
  logic [7:0] fb[2] = '{8'h0, 8'h0};
  logic [7:0] lb[2] = '{8'h0, 8'h0};
  logic okv[2] = '{1'b0, 1'b0};
  int b_nb[2], b_ns[2], b_ne[2];
  always @(negedge clk125) begin
    if (rx0.rx_valid) begin
      nb[0]++;
      if (rx0.rx_sop) begin ns[0]++; fb[0] = rx0.rx_data; end
      if (rx0.rx_eop) begin ne[0]++; lb[0] = rx0.rx_data; okv[0] = rx0.rx_crc_ok; end
    end
    if (rx1.rx_valid) begin
      nb[1]++;
      if (rx1.rx_sop) begin ns[1]++; fb[1] = rx1.rx_data; end
      if (rx1.rx_eop) begin ne[1]++; lb[1] = rx1.rx_data; okv[1] = rx1.rx_crc_ok; end
    end
  end
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  logic [7:0] frm[$];
  function automatic logic [31:0] fcs_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = r[0] ^ d[i] ? (r >> 1) ^ 32'hedb8_8320 : r >> 1;
    return r;
  endfunction
  task automatic build(input logic [47:0] dst, input int npay);
    logic [31:0] c;
    logic [47:0] src;
    c = '1;
    src = 48'h0088_dab8_bf08;
    frm = {};
    for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
    frm.push_back(8'h19);
    frm.push_back(8'h19);
    repeat (npay) frm.push_back(8'h39);
    foreach (frm[i]) c = fcs_step(c, frm[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask
  task automatic drive(input logic [7:0] b, input logic dv, input logic er);
    @(posedge clk125);
    #1;
    rxd = b[3:0];
    rxctl = dv ^ er;
    @(negedge clk125);
    #1;
    rxd = b[7:4];
    rxctl = dv;
  endtask
  task automatic send(input int er_at);
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hd5, 1'b1, 1'b0);
    foreach (frm[i]) drive(frm[i], 1'b1, i == er_at);
    drive(8'h00, 1'b0, 1'b0);
  endtask
  task automatic snap();
    b_nb = nb;
    b_ns = ns;
    b_ne = ne;
  endtask
  task automatic settle();
    repeat (3) drive(8'h00, 1'b0, 1'b0);
  endtask
  task automatic expect_frame(input int d, input string tag, input int n, input logic [7:0] first, input logic ok);
    check({tag, "_bytes"}, nb[d] - b_nb[d], n);
    check({tag, "_sop"}, ns[d] - b_ns[d], n > 0);
    check({tag, "_eop"}, ne[d] - b_ne[d], n > 0);
    if (n > 0) begin
      check({tag, "_first"}, fb[d], first);
      check({tag, "_last"}, lb[d], 8'h39);
      check({tag, "_crc_ok"}, okv[d], ok);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk125);
    #1;
    check("rst_valid", rx0.rx_valid, 0);
    check("rst_data", rx0.rx_data, 0);
    check("rst_sop_eop_ok", {rx0.rx_sop, rx0.rx_eop, rx0.rx_crc_ok}, 0);
    check("rst_frame_cnt", frame_cnt0, 0);
    check("rst_err_cnt", err_cnt0, 0);
    rst_n = 1'b1;
    build(48'h08bf_b8da_8800, 200);
    snap();
    send(-1);
    settle();
    expect_frame(0, "good", 214, 8'h08, 1'b1);
    check("good_frame_cnt", frame_cnt0, 1);
    check("good_err_cnt", err_cnt0, 0);
    frm[50] = frm[50] ^ 8'h01;
    snap();
    send(-1);
    settle();
    expect_frame(0, "flip", 214, 8'h08, 1'b0);
    check("flip_err_cnt", err_cnt0, 1);
    check("flip_frame_cnt", frame_cnt0, 1);
    build(48'h08bf_b8da_8801, 200);
    snap();
    send(-1);
    settle();
    expect_frame(0, "dst_miss", 0, 8'h00, 1'b0);
    check("dst_miss_frame_cnt", frame_cnt0, 1);
    check("dst_miss_err_cnt", err_cnt0, 1);
    expect_frame(1, "promisc", 214, 8'h08, 1'b1);
    check("promisc_frame_cnt", frame_cnt1, 2);
    build(48'hffff_ffff_ffff, 200);
    snap();
    send(-1);
    settle();
    expect_frame(0, "bcast", 214, 8'hff, 1'b1);
    check("bcast_frame_cnt", frame_cnt0, 2);
    build(48'h08bf_b8da_8800, 200);
    snap();
    send(100);
    settle();
    expect_frame(0, "rx_er", 214, 8'h08, 1'b0);
    check("rx_er_err_cnt", err_cnt0, 2);
    build(48'h08bf_b8da_8800, 42);
    snap();
    send(-1);
    settle();
    expect_frame(0, "runt", 56, 8'h08, 1'b0);
    check("runt_err_cnt", err_cnt0, 3);
    build(48'h08bf_b8da_8800, 1501);
    snap();
    send(-1);
    settle();
    expect_frame(0, "giant", 1515, 8'h08, 1'b0);
    check("giant_err_cnt", err_cnt0, 4);
    build(48'h08bf_b8da_8800, 200);
    snap();
    send(-1);
    send(-1);
    settle();
    check("b2b_bytes", nb[0] - b_nb[0], 428);
    check("b2b_sop", ns[0] - b_ns[0], 2);
    check("b2b_eop", ne[0] - b_ne[0], 2);
    check("b2b_crc_ok", okv[0], 1);
    check("b2b_frame_cnt", frame_cnt0, 4);
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hd5, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) drive(frm[i], 1'b1, 1'b0);
    @(posedge clk125);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rx0.rx_valid, 0);
    check("mid_rst_data", rx0.rx_data, 0);
    check("mid_rst_frame_cnt", frame_cnt0, 0);
    check("mid_rst_err_cnt", err_cnt0, 0);
    @(negedge clk125);
    #2;
    rst_n = 1'b1;
    snap();
    for (int i = 50; i < frm.size(); i++) drive(frm[i], 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    settle();
    check("aborted_bytes", nb[0] - b_nb[0], 0);
    check("aborted_cnts", {frame_cnt0, err_cnt0}, 0);
    snap();
    send(-1);
    settle();
    expect_frame(0, "after_rst", 214, 8'h08, 1'b1);
    check("after_rst_frame_cnt", frame_cnt0, 1);
    check("after_rst_err_cnt", err_cnt0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/net_rx.md
# net_rx

RGMII receive front end for the 125 MHz gigabit link. It reassembles DDR nibbles into bytes and strips preamble/SFD. It filters on destination MAC, checks the Ethernet FCS (CRC-32), and streams frame bytes (header + payload, FCS removed) to downstream logic with start/end markers and a good/bad verdict on the last byte. It is the receive-side counterpart of the `net` frame transmitter and decodes exactly the format `net` produces.

## Interface
- MAC_ADDR, 48'h08bf_b8da_8800, accepted destination address (first byte on wire = MSB)
- PROMISC, 0, 1 = accept any destination; broadcast ff:ff:ff:ff:ff:ff is always accepted
- MIN_LEN, 64, minimum frame length in bytes including FCS
- MAX_LEN, 1518, maximum frame length in bytes including FCS
- clk125  in  1  125 MHz clock; RGMII receive data is aligned to it and sampled on both edges
- rst_n  in  1  asynchronous active-low reset
- rxctl  in  1  RGMII control: RX_DV at rising edge, RX_DV^RX_ER at falling edge
- rxd  in  4  RGMII data: low nibble sampled at falling edge, high nibble at the following rising edge
- rx_data  out  8  frame byte
- rx_valid  out  1  rx_data valid this cycle (no backpressure)
- rx_sop  out  1  first byte of frame (first destination-MAC byte)
- rx_eop  out  1  last non-FCS byte of frame
- rx_crc_ok  out  1  valid only with rx_eop: FCS good, no RX_ER, length within MIN_LEN..MAX_LEN
- frame_cnt  out  16  count of frames ending with rx_crc_ok=1, wraps
- err_cnt  out  16  count of accepted-address frames ending with rx_crc_ok=0, wraps

## Operation
- Byte capture: fall-edge register holds the low nibble and ctl_f; the rising edge forms byte = {rxd, low}, dv = rxctl, er = rxctl ^ ctl_f.
- FSM (rising edge, on captured byte/dv/er):
  - IDLE: dv=1 and byte=0x55 -> PRE; dv=1 with any other byte -> DROP.
  - PRE: 0x55 stays (any count 1..7 accepted); 0xD5 -> DATA, clearing CRC to 0xFFFFFFFF and len to 0; any other byte -> DROP; dv=0 -> IDLE.
  - DATA: every byte updates CRC, LSB-first reflected, poly 0xEDB88320, and len (11 bits, saturates at 2047); er=1 sets sticky err; bytes 0..5 compared to MAC_ADDR/broadcast, and a mismatch with PROMISC=0 -> DROP with no output emitted. dv=0 -> IDLE and ends the frame.
  - DROP: ignore until dv=0 -> IDLE. No output and no counter change.
- FCS strip: 5-byte holdback shift register. Byte k is emitted when byte k+5 is captured. At frame end, the oldest held byte (byte L-5, L = total bytes after SFD) is emitted with rx_eop. The four FCS bytes are discarded.
- Address filter decision precedes the first emit (byte 0 leaves at byte 5 capture), so rejected frames produce no rx_valid.
- Verdict: crc_ok = (CRC register after all L bytes == 0xDEBB20E3) & !err & MIN_LEN<=L<=MAX_LEN.
- Frames with L<5 end with no output and increment err_cnt if the address already passed; otherwise no output and no count.
- Counters increment in the cycle rx_eop is asserted.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_sop=0, rx_eop=0, rx_crc_ok=0, frame_cnt=0, err_cnt=0, FSM=IDLE, holdback cleared.
- Byte k captured at rising edge n -> byte k-5 on rx_data during cycle n+1 (registered outputs).
- dv=0 sampled at rising edge m -> rx_eop, rx_valid, rx_crc_ok asserted in cycle m+1; counters updated at end of cycle m+1.
- rx_sop and rx_eop are single-cycle and coincide with rx_valid. rx_valid is contiguous from sop to eop.
- Back-to-back frames: minimum one dv=0 cycle between frames is sufficient; a new preamble may start the cycle after dv falls.
- Reset mid-frame: all outputs drop to reset values immediately. Receive resumes only from IDLE on the next preamble; the current frame is not completed.

## Test plan
- Frame matching net's output (7×0x55, 0xD5, header 08 bf b8 da 88 00 00 88 da b8 bf 08 19 19, 200×0x39, valid FCS) -> 214 rx_valid bytes with sop on 0x08 and eop on the last 0x39; rx_crc_ok=1; frame_cnt=1.
- Same frame with one payload bit flipped -> 214 bytes, rx_crc_ok=0, err_cnt=1, frame_cnt unchanged.
- Destination 08:bf:b8:da:88:01, PROMISC=0 -> no rx_valid, counters unchanged. Repeat with PROMISC=1 -> full frame and crc_ok=1. Broadcast with PROMISC=0 -> accepted.
- RX_ER pulsed (falling-edge ctl=0) for one cycle mid-payload of a valid-FCS frame -> rx_crc_ok=0, err_cnt+1.
- Runt: 60-byte frame with correct FCS -> 56 bytes output, rx_crc_ok=0. 1519-byte frame -> rx_crc_ok=0.
- Two valid frames separated by one idle cycle -> two sop/eop pairs, frame_cnt=2. Then assert rst_n low mid-third-frame -> outputs zero, counters 0, next frame received normally.
